// File: rtl/fdiv_seq.sv
// Multi-cycle binary32 divider: restoring radix-2 mantissa loop, one quotient bit per cycle.
// Truncating, subnormals flushed to zero, divide-by-zero and overflow saturate to infinity.
module fdiv_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        req,
  output logic        ready,
  output logic [31:0] y,
  output logic        valid,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, DIV, PACK} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_s;
  logic [7:0]  r_e1;
  logic [7:0]  r_e2;
  logic        r_z1;
  logic        r_z2;
  logic [23:0] r_m2;
  logic [24:0] r_rem;
  logic [24:0] r_q;
  logic [4:0]  r_cnt;
  logic [31:0] r_y;
  logic        r_valid;
  logic        r_ovf;

  logic        w_accept;
  logic [25:0] w_diff;
  logic        w_ge;
  logic [32:0] w_pack;

  // Special-value priority and exponent saturation; returns {ovf, y}.
  function automatic logic [32:0] pack_result(
    input logic        s,
    input logic [7:0]  e1,
    input logic [7:0]  e2,
    input logic        z1,
    input logic        z2,
    input logic [24:0] q
  );
    logic signed [9:0] ea;
    logic [22:0]       m;
    ea = {2'b00, e1} - {2'b00, e2} + (q[24] ? 10'd127 : 10'd126);
    m  = q[24] ? q[23:1] : q[22:0];
    if (z1)                  pack_result = {1'b0, s, 31'd0};
    else if (z2)             pack_result = {1'b1, s, 8'hFF, 23'd0};
    else if (ea >= 10'sd255) pack_result = {1'b1, s, 8'hFF, 23'd0};
    else if (ea <= 10'sd0)   pack_result = {1'b0, s, 31'd0};
    else                     pack_result = {1'b0, s, ea[7:0], m};
  endfunction

  assign ready    = (r_state == IDLE);
  assign w_accept = ready && req;
  // Remainder stays below twice the divisor, so compare first and then shift.
  assign w_diff   = {1'b0, r_rem} - {2'b00, r_m2};
  assign w_ge     = ~w_diff[25];
  assign w_pack   = pack_result(r_s, r_e1, r_e2, r_z1, r_z2, r_q);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req) w_next = DIV;
      DIV:     if (r_cnt == 5'd0) w_next = PACK;
      PACK:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s     <= 1'b0;
      r_e1    <= 8'd0;
      r_e2    <= 8'd0;
      r_z1    <= 1'b0;
      r_z2    <= 1'b0;
      r_m2    <= 24'd0;
      r_rem   <= 25'd0;
      r_q     <= 25'd0;
      r_cnt   <= 5'd0;
      r_y     <= 32'd0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_s   <= x1[31] ^ x2[31];
          r_e1  <= x1[30:23];
          r_e2  <= x2[30:23];
          r_z1  <= (x1[30:23] == 8'd0);
          r_z2  <= (x2[30:23] == 8'd0);
          r_m2  <= {1'b1, x2[22:0]};
          r_rem <= {2'b01, x1[22:0]};
          r_q   <= 25'd0;
          r_cnt <= 5'd24;
        end
        DIV: begin
          r_rem <= w_ge ? {w_diff[23:0], 1'b0} : {r_rem[23:0], 1'b0};
          r_q   <= {r_q[23:0], w_ge};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        PACK: begin
          r_y     <= w_pack[31:0];
          r_ovf   <= w_pack[32];
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign y     = r_y;
  assign valid = r_valid;
  assign ovf   = r_ovf;

endmodule
